// File: rtl/bcd_countdown_timer.sv
// Three-digit BCD countdown timer: loads a preset number of seconds, decrements
// once per prescaled tick with borrow ripple, flags expiry and drives 7-seg outputs.
module bcd_countdown_timer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [11:0] preset,
    input  logic        start,
    input  logic        pause,
    output logic [11:0] digits,
    output logic        running,
    output logic        expired,
    output logic        done_pulse,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2
);

    localparam int unsigned PW   = 26;
    localparam int unsigned DW   = 4;
    localparam int unsigned VW   = 3 * DW;
    localparam int unsigned SEGW = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [VW-1:0]     digits_q, digits_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              pulse_d;
    logic              running_q, expired_q, pulse_q;
    logic [SEGW-1:0]   hex0_q, hex1_q, hex2_q;
    logic [VW-1:0]     dec_c;
    logic [VW-1:0]     preset_sat_c;

    function automatic logic [DW-1:0] sat9(input logic [DW-1:0] n);
        return (n > DW'(9)) ? DW'(9) : n;
    endfunction

    function automatic logic [SEGW-1:0] seg7(input logic [DW-1:0] n);
        logic [SEGW-1:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Ones borrow from tens when 0, tens borrow from hundreds when 0 and borrowed.
    function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
        logic [DW-1:0] h, t, o;
        h = v[11:8];
        t = v[7:4];
        o = v[3:0];
        if (o != DW'(0)) begin
            o = o - DW'(1);
        end else begin
            o = DW'(9);
            if (t != DW'(0)) begin
                t = t - DW'(1);
            end else begin
                t = DW'(9);
                h = h - DW'(1);
            end
        end
        return {h, t, o};
    endfunction

    assign dec_c        = bcd_dec(digits_q);
    assign preset_sat_c = {sat9(preset[11:8]), sat9(preset[7:4]), sat9(preset[3:0])};

    // Next-state logic: load dominates, then per-state pause/start/tick handling.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        presc_d  = presc_q;
        pulse_d  = 1'b0;
        if (load) begin
            digits_d = preset_sat_c;
            presc_d  = '0;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (digits_q != '0) begin
                            state_d = RUN;
                            presc_d = '0;
                        end else begin
                            state_d = DONE;
                            pulse_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_d  = '0;
                        digits_d = dec_c;
                        if (dec_c == '0) begin
                            state_d = DONE;
                            pulse_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (start && !pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Flags and segments are registered from the next state so they track digits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            digits_q  <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
            hex0_q    <= seg7(DW'(0));
            hex1_q    <= seg7(DW'(0));
            hex2_q    <= seg7(DW'(0));
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            presc_q   <= presc_d;
            running_q <= (state_d == RUN);
            expired_q <= (state_d == DONE);
            pulse_q   <= pulse_d;
            hex0_q    <= seg7(digits_d[3:0]);
            hex1_q    <= seg7(digits_d[7:4]);
            hex2_q    <= seg7(digits_d[11:8]);
        end
    end

    assign digits     = digits_q;
    assign running    = running_q;
    assign expired    = expired_q;
    assign done_pulse = pulse_q;
    assign hex0       = hex0_q;
    assign hex1       = hex1_q;
    assign hex2       = hex2_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: integer-seconds reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_bcd_countdown_timer;

    localparam int unsigned TD = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        reset, load, start, pause;
    logic [11:0] preset;
    logic [11:0] digits;
    logic        running, expired, done_pulse;
    logic [6:0]  hex0, hex1, hex2;

    int n_cmp  = 0;
    int n_fail = 0;

    bcd_countdown_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .load(load), .preset(preset),
        .start(start), .pause(pause), .digits(digits), .running(running),
        .expired(expired), .done_pulse(done_pulse),
        .hex0(hex0), .hex1(hex1), .hex2(hex2)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10];
    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0011000;
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining time as a plain integer, phase as cycles since last tick.
    int m_mode = M_IDLE;
    int m_val  = 0;
    int m_phase = 0;
    bit m_pulse = 1'b0;
    bit m_valid = 1'b0;

    function automatic int nib_sat(input logic [3:0] n);
        return (n > 4'd9) ? 9 : int'(n);
    endfunction

    always @(posedge clk) begin
        m_valid = 1'b1;
        m_pulse = 1'b0;
        if (!reset) begin
            m_mode = M_IDLE; m_val = 0; m_phase = 0;
        end else if (load) begin
            m_val = nib_sat(preset[11:8]) * 100 + nib_sat(preset[7:4]) * 10 + nib_sat(preset[3:0]);
            m_phase = 0;
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (start) begin
                if (m_val != 0) begin
                    m_mode = M_RUN; m_phase = 0;
                end else begin
                    m_mode = M_DONE; m_pulse = 1'b1;
                end
            end
        end else if (m_mode == M_RUN) begin
            if (pause) begin
                m_mode = M_PAUSE;
            end else if (m_phase == int'(TD) - 1) begin
                m_phase = 0;
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_mode = M_DONE; m_pulse = 1'b1;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end else if (m_mode == M_PAUSE) begin
            if (start && !pause) m_mode = M_RUN;
        end
    end

    function automatic logic [11:0] m_digits();
        return {4'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10)};
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("model digits", digits, m_digits());
            check("model running", 12'(running), 12'(m_mode == M_RUN));
            check("model expired", 12'(expired), 12'(m_mode == M_DONE));
            check("model done_pulse", 12'(done_pulse), 12'(m_pulse));
            check("model hex0", 12'(hex0), 12'(seg_tab[m_val % 10]));
            check("model hex1", 12'(hex1), 12'(seg_tab[(m_val / 10) % 10]));
            check("model hex2", 12'(hex2), 12'(seg_tab[m_val / 100]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; preset = 12'h000;
        step(2);
        check("reset digits", digits, 12'h000);
        check("reset running", 12'(running), 12'h0);
        check("reset hex0", 12'(hex0), 12'(7'b1000000));

        // Countdown from 012 to expiry.
        reset = 1'b1; load = 1'b1; preset = 12'h012;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        check("start running", 12'(running), 12'h1);
        step(4);  check("t1 digits 011", digits, 12'h011);
        step(4);  check("t1 digits 010", digits, 12'h010);
        step(4);  check("t1 digits 009", digits, 12'h009);
        step(35); check("t1 digits 001", digits, 12'h001);
        check("t1 not expired yet", 12'(expired), 12'h0);
        step(1);
        check("t1 digits 000", digits, 12'h000);
        check("t1 done_pulse", 12'(done_pulse), 12'h1);
        check("t1 expired", 12'(expired), 12'h1);
        check("t1 hex0", 12'(hex0), 12'(7'b1000000));
        step(1);
        check("t1 done_pulse drop", 12'(done_pulse), 12'h0);
        check("t1 expired held", 12'(expired), 12'h1);

        // Double borrow from 100.
        load = 1'b1; preset = 12'h100;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        check("t2 digits 099", digits, 12'h099);
        check("t2 hex2", 12'(hex2), 12'(7'b1000000));
        check("t2 hex1", 12'(hex1), 12'(7'b0011000));
        check("t2 hex0", 12'(hex0), 12'(7'b0011000));

        // Pause two cycles into a tick period, hold ten cycles, resume.
        load = 1'b1; preset = 12'h005;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        pause = 1'b1;
        step(10);
        check("t3 paused digits", digits, 12'h005);
        check("t3 paused running", 12'(running), 12'h0);
        pause = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        check("t3 resumed running", 12'(running), 12'h1);
        step(2);  check("t3 before tick", digits, 12'h005);
        step(1);  check("t3 digits 004", digits, 12'h004);

        // Saturating load, then start from zero.
        load = 1'b1; preset = 12'hA5F;
        step(1);
        check("t4 saturated load", digits, 12'h959);
        preset = 12'h000;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        check("t4 zero-start expired", 12'(expired), 12'h1);
        check("t4 zero-start pulse", 12'(done_pulse), 12'h1);
        check("t4 zero-start digits", digits, 12'h000);
        step(1);
        check("t4 pulse drop", 12'(done_pulse), 12'h0);

        // DONE ignores start/pause; load leaves it.
        start = 1'b1; step(1);
        start = 1'b0; pause = 1'b1; step(1);
        start = 1'b1; step(1);
        start = 1'b0; pause = 1'b0; step(1);
        check("t5 still expired", 12'(expired), 12'h1);
        check("t5 no repulse", 12'(done_pulse), 12'h0);
        check("t5 not running", 12'(running), 12'h0);
        load = 1'b1; preset = 12'h003;
        step(1);
        load = 1'b0;
        check("t5 reload expired", 12'(expired), 12'h0);
        check("t5 reload digits", digits, 12'h003);

        // Reset mid-run, then load mid-run.
        load = 1'b1; preset = 12'h010;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(12);
        check("t6 digits 007", digits, 12'h007);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        check("t6 reset digits", digits, 12'h000);
        check("t6 reset running", 12'(running), 12'h0);
        check("t6 reset expired", 12'(expired), 12'h0);
        load = 1'b1; preset = 12'h030;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(6);
        load = 1'b1; preset = 12'h020;
        step(1);
        load = 1'b0;
        check("t6 load digits", digits, 12'h020);
        check("t6 load running", 12'(running), 12'h0);
        step(8);
        check("t6 idle hold", digits, 12'h020);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
